pwm_multi_channel: RTL and testbench
====================================

// Module: pwm_multi_channel
// PURPOSE
//  Parametrised N-channel PWM generator with a shared timebase, programmable period,
//  edge- or center-aligned counting and double-buffered (shadow) duty/period registers.
//  Shadow values commit only at a period boundary, so updates never glitch a pulse.
//  Drives motor/LED PWM pins; exposes the timebase count for sampling alignment.
// PARAMETERS
//  N_CH        4      number of PWM channels (1..16)
//  CNT_W       10     counter, period and duty width in bits
//  DEF_PERIOD  1023   reset value of the active and shadow period
//  POL_INV     '0     N_CH-bit mask; bit c=1 inverts channel c output
// PORTS
//  clk         in   1               clock
//  arst        in   1               reset, synchronous, active-low
//  en          in   1               timebase enable
//  wr_en       in   1               duty shadow write strobe
//  wr_ch       in   clog2(N_CH)     channel index for the duty write
//  wr_duty     in   CNT_W           duty value (compare threshold)
//  cfg_we      in   1               period/mode shadow write strobe
//  cfg_period  in   CNT_W           period value P
//  cfg_mode    in   1               0=edge-aligned, 1=center-aligned
//  upd_pending out  1               shadow holds uncommitted writes
//  upd_done    out  1               1-cycle pulse when the shadow is committed
//  cnt_o       out  CNT_W           current timebase count
//  pwm_o       out  N_CH            PWM outputs, registered
// BEHAVIOUR
//  - Reset (arst=0 at posedge): cnt=0, dir=up, active/shadow period=DEF_PERIOD,
//    mode=edge, all duties=0, upd_pending=0, upd_done=0, pwm_o=POL_INV.
//  - Edge mode: cnt 0,1..P,0,...; period length P+1 cycles.
//  - Center mode: cnt 0,1..P,P-1..1,0,...; dir flips at P; period length 2P cycles.
//    P=0 in either mode: cnt held at 0.
//  - eop = last cycle of a period (the next cnt is 0 and starts a new period).
//    Edge: cnt==P. Center: cnt==1 with dir=down, or cnt==P==1. P=0: every cycle.
//  - Compare: pwm_o[c] <= (cnt < duty_act[c]) ^ POL_INV[c]; one cycle of latency
//    from cnt to pin.
//    duty=0 gives a constant inactive level; duty>P gives a constant active level.
//    Center mode: high width = 2*duty-1 cycles, centred on cnt=0.
//  - Writes: wr_en writes shadow duty[wr_ch]; cfg_we writes shadow period+mode.
//    Either write sets upd_pending. wr_ch>=N_CH is ignored (no pending set).
//  - Commit: on the edge ending an eop cycle with upd_pending=1, copy all shadows
//    to active, reset dir=up, clear upd_pending, and pulse upd_done the next cycle.
//    New values govern the very next period from its cnt=0.
//  - Simultaneous write and commit: commit takes the pre-write shadow. The write
//    lands in the shadow, upd_pending stays 1, and it commits at the next eop.
//  - en=0: cnt and dir held at 0/up, pwm_o forced to POL_INV, eop treated as 1
//    (commits happen immediately). en rising starts at cnt=0 with current actives.
//  - Reset mid-period: all state returns to reset values next cycle; pending
//    writes are discarded.
//  - Arithmetic is unsigned CNT_W, with no wrap beyond P.
// STRUCTURE
//  - Package pwm_pkg: typedef enum {PWM_EDGE, PWM_CENTER} pwm_mode_t; CH_IDX_W
//    helper; DEF_PERIOD default constant.
//  - Sub-module pwm_timebase: cnt, dir and eop generation from P, mode and en.
//  - Top: shadow/active register banks, pending/done logic, per-channel compare
//    with a generate loop.
// TESTING (N_CH=4, CNT_W=10, POL_INV=0)
//  1 Reset defaults: arst=0 for 2 cycles -> pwm_o=0, cnt_o=0, upd_pending=0;
//    then en=1 -> cnt_o cycles 0..1023.
//  2 Edge mode: P=9, duty[0]=3 committed -> pwm_o[0] high 3 of every 10 cycles,
//    rising 1 cycle after cnt_o=0.
//  3 Center mode: P=4, duty[1]=2 -> cnt_o 0,1,2,3,4,3,2,1; pwm_o[1] high 3 of
//    8 cycles, centred on cnt=0.
//  4 Glitch-free update: with P=9 and cnt=5, write duty[0]=7 -> upd_pending=1;
//    old duty holds to cnt=9; upd_done pulses once; the next period is 7-high.
//  5 Boundary values: duty=0 -> constant 0; duty=10 with P=9 -> constant 1;
//    P=0 -> cnt_o stays 0; wr_ch=5 -> ignored.
//  6 Write during the eop cycle and reset mid-period: commit uses the old shadow
//    and pending stays 1; arst=0 at cnt=6 -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and constants for the multi-channel PWM block.
package pwm_pkg;

  // Counting scheme of the shared timebase.
  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_t;

  // Counting direction; only meaningful in center-aligned mode.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_t;

  // Period loaded into both active and shadow registers at reset.
  localparam int PWM_DEF_PERIOD = 1023;

  // Width of a channel index; never zero so a single-channel build still has a port.
  function automatic int ch_idx_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: produces the count, its direction and the end-of-period flag.
// A disabled timebase sits at count 0 counting up and reports every cycle as the
// end of a period, so pending updates commit at once while stopped.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_period,
  input  pwm_mode_t        i_mode,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_eop
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  pwm_dir_t         r_dir;
  pwm_dir_t         w_dir_nxt;
  logic             w_eop;

  // End-of-period detection and next count/direction.
  always_comb begin
    w_eop     = 1'b1;
    w_cnt_nxt = r_cnt;
    w_dir_nxt = r_dir;
    if (i_en && (i_period != '0)) begin
      if (i_mode == PWM_EDGE) begin
        w_eop = (r_cnt == i_period);
      end else begin
        // P=1 never reaches a down-count, so cnt==1 is already the last cycle.
        w_eop = (r_cnt == ONE) && ((r_dir == DIR_DOWN) || (i_period == ONE));
      end
    end
    if (w_eop) begin
      w_cnt_nxt = '0;
      w_dir_nxt = DIR_UP;
    end else if (i_mode == PWM_EDGE) begin
      w_cnt_nxt = r_cnt + ONE;
    end else if (r_dir == DIR_UP) begin
      if (r_cnt == i_period) begin
        w_cnt_nxt = r_cnt - ONE;
        w_dir_nxt = DIR_DOWN;
      end else begin
        w_cnt_nxt = r_cnt + ONE;
      end
    end else begin
      w_cnt_nxt = r_cnt - ONE;
    end
  end

  // Count and direction registers.
  always_ff @(posedge clk) begin
    if (!arst) begin
      r_cnt <= '0;
      r_dir <= DIR_UP;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_dir <= w_dir_nxt;
    end
  end

  assign o_cnt = r_cnt;
  assign o_eop = w_eop;

endmodule

// File: rtl/pwm_multi_channel.sv
// N-channel PWM generator with a shared timebase and double-buffered duty/period.
// Writes land in shadow registers; the whole shadow set is copied to the active
// set on the edge that ends a period, so a running pulse is never cut short.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int              N_CH       = 4,
  parameter int              CNT_W      = 10,
  parameter int              DEF_PERIOD = PWM_DEF_PERIOD,
  parameter logic [N_CH-1:0] POL_INV    = '0,
  localparam int             CH_IDX_W   = ch_idx_w(N_CH)
) (
  input  logic                clk,
  input  logic                arst,
  input  logic                en,
  input  logic                wr_en,
  input  logic [CH_IDX_W-1:0] wr_ch,
  input  logic [CNT_W-1:0]    wr_duty,
  input  logic                cfg_we,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic                cfg_mode,
  output logic                upd_pending,
  output logic                upd_done,
  output logic [CNT_W-1:0]    cnt_o,
  output logic [N_CH-1:0]     pwm_o
);

  logic [CNT_W-1:0] r_sh_duty  [N_CH];
  logic [CNT_W-1:0] r_act_duty [N_CH];
  logic [CNT_W-1:0] r_sh_period;
  logic [CNT_W-1:0] r_act_period;
  pwm_mode_t        r_sh_mode;
  pwm_mode_t        r_act_mode;
  logic             r_pending;
  logic             r_done;
  logic [N_CH-1:0]  r_pwm;

  logic [CNT_W-1:0] w_cnt;
  logic             w_eop;
  logic             w_duty_wr;
  logic             w_commit;
  logic [N_CH-1:0]  w_pwm_nxt;

  pwm_timebase #(
    .CNT_W(CNT_W)
  ) u_timebase (
    .clk     (clk),
    .arst    (arst),
    .i_en    (en),
    .i_period(r_act_period),
    .i_mode  (r_act_mode),
    .o_cnt   (w_cnt),
    .o_eop   (w_eop)
  );

  // Out-of-range channel writes are dropped entirely; commit only on a period boundary.
  assign w_duty_wr = wr_en && (int'(wr_ch) < N_CH);
  assign w_commit  = w_eop && r_pending;

  // Shadow/active banks: the commit copies the shadow as it was before any same-cycle write.
  always_ff @(posedge clk) begin
    if (!arst) begin
      for (int c = 0; c < N_CH; c++) begin
        r_sh_duty[c]  <= '0;
        r_act_duty[c] <= '0;
      end
      r_sh_period  <= CNT_W'(DEF_PERIOD);
      r_act_period <= CNT_W'(DEF_PERIOD);
      r_sh_mode    <= PWM_EDGE;
      r_act_mode   <= PWM_EDGE;
    end else begin
      if (w_commit) begin
        for (int c = 0; c < N_CH; c++) begin
          r_act_duty[c] <= r_sh_duty[c];
        end
        r_act_period <= r_sh_period;
        r_act_mode   <= r_sh_mode;
      end
      if (w_duty_wr) begin
        r_sh_duty[wr_ch] <= wr_duty;
      end
      if (cfg_we) begin
        r_sh_period <= cfg_period;
        r_sh_mode   <= pwm_mode_t'(cfg_mode);
      end
    end
  end

  // Pending/done tracking: a write in the commit cycle keeps pending set for the next boundary.
  always_ff @(posedge clk) begin
    if (!arst) begin
      r_pending <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_duty_wr || cfg_we) begin
        r_pending <= 1'b1;
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Per-channel threshold compare against the shared count.
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign w_pwm_nxt[c] = (w_cnt < r_act_duty[c]) ^ POL_INV[c];
  end

  // Output pins are registered; a stopped timebase parks every pin at its idle level.
  always_ff @(posedge clk) begin
    if (!arst) begin
      r_pwm <= POL_INV;
    end else if (!en) begin
      r_pwm <= POL_INV;
    end else begin
      r_pwm <= w_pwm_nxt;
    end
  end

  assign upd_pending = r_pending;
  assign upd_done    = r_done;
  assign cnt_o       = w_cnt;
  assign pwm_o       = r_pwm;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel. Outputs are sampled and inputs driven on the
// falling clock edge. A second, small instance (5 channels, inverted pins) covers
// out-of-range channel writes and output polarity.
module tb_pwm_multi_channel;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (N_CH=4, CNT_W=10) ----------------
  logic       en = 1'b0, wr_en = 1'b0, cfg_we = 1'b0, cfg_mode = 1'b0;
  logic [1:0] wr_ch = '0;
  logic [9:0] wr_duty = '0, cfg_period = '0;
  logic       upd_pending, upd_done;
  logic [9:0] cnt_o;
  logic [3:0] pwm_o;

  pwm_multi_channel #(
    .N_CH(4), .CNT_W(10), .DEF_PERIOD(1023), .POL_INV(4'b0000)
  ) u_dut (
    .clk(clk), .arst(arst), .en(en),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
    .cfg_we(cfg_we), .cfg_period(cfg_period), .cfg_mode(cfg_mode),
    .upd_pending(upd_pending), .upd_done(upd_done), .cnt_o(cnt_o), .pwm_o(pwm_o)
  );

  // ---------------- second DUT (N_CH=5, CNT_W=4, inverted ch1/ch4) ----------------
  logic       en5 = 1'b0, wr_en5 = 1'b0, cfg_we5 = 1'b0, cfg_mode5 = 1'b0;
  logic [2:0] wr_ch5 = '0;
  logic [3:0] wr_duty5 = '0, cfg_period5 = '0;
  logic       upd_pending5, upd_done5;
  logic [3:0] cnt5;
  logic [4:0] pwm5;

  pwm_multi_channel #(
    .N_CH(5), .CNT_W(4), .DEF_PERIOD(15), .POL_INV(5'b10010)
  ) u_dut5 (
    .clk(clk), .arst(arst), .en(en5),
    .wr_en(wr_en5), .wr_ch(wr_ch5), .wr_duty(wr_duty5),
    .cfg_we(cfg_we5), .cfg_period(cfg_period5), .cfg_mode(cfg_mode5),
    .upd_pending(upd_pending5), .upd_done(upd_done5), .cnt_o(cnt5), .pwm_o(pwm5)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  // Center mode, P=4: count per cycle within the 8-cycle period, and the
  // pin level for k>=1 indexed by k%8 (pin follows count by one cycle).
  int cnt_tab_c[8] = '{0, 1, 2, 3, 4, 3, 2, 1};
  int pwm_tab_c[8] = '{1, 1, 1, 0, 0, 0, 0, 0};

  // ---------------- driver tasks ----------------
  // Stop the timebase, load period/mode and duties for ch0/ch1, let the commit
  // happen while stopped, then restart. Returns on the falling edge of cycle k=0
  // (count 0, pins idle).
  task automatic load_and_start(input logic [9:0] p, input logic m,
                                input logic [9:0] d0, input logic [9:0] d1);
    @(negedge clk);
    en = 1'b0; cfg_we = 1'b1; cfg_period = p; cfg_mode = m;
    wr_en = 1'b1; wr_ch = 2'd0; wr_duty = d0;
    @(negedge clk);
    cfg_we = 1'b0; wr_ch = 2'd1; wr_duty = d1;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    en = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    arst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (pwm_o !== 4'b0000) begin n_errors++; $display("FAIL rst_pwm got %b exp %b", pwm_o, 4'b0000); end
    n_checks++;
    if (cnt_o !== 10'd0) begin n_errors++; $display("FAIL rst_cnt got %0d exp 0", cnt_o); end
    n_checks++;
    if (upd_pending !== 1'b0) begin n_errors++; $display("FAIL rst_pending got %b exp 0", upd_pending); end
    n_checks++;
    if (upd_done !== 1'b0) begin n_errors++; $display("FAIL rst_done got %b exp 0", upd_done); end
    n_checks++;
    if (pwm5 !== 5'b10010) begin n_errors++; $display("FAIL rst_pwm_inv got %b exp %b", pwm5, 5'b10010); end
    arst = 1'b1;
    en   = 1'b1;
    for (int k = 0; k <= 1024; k++) begin
      n_checks++;
      if (cnt_o !== 10'(k % 1024)) begin
        n_errors++; $display("FAIL rst_cnt_seq k=%0d got %0d exp %0d", k, cnt_o, k % 1024);
      end
      if (k == 512) begin
        n_checks++;
        if (pwm_o !== 4'b0000) begin n_errors++; $display("FAIL rst_duty0 got %b exp 0000", pwm_o); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_edge();
    logic [3:0] exp_pwm;
    load_and_start(10'd9, 1'b0, 10'd3, 10'd0);
    for (int k = 0; k < 30; k++) begin
      exp_pwm = 4'b0000;
      if (k > 0 && ((k - 1) % 10) < 3) exp_pwm[0] = 1'b1;
      n_checks++;
      if (cnt_o !== 10'(k % 10)) begin
        n_errors++; $display("FAIL edge_cnt k=%0d got %0d exp %0d", k, cnt_o, k % 10);
      end
      n_checks++;
      if (pwm_o !== exp_pwm) begin
        n_errors++; $display("FAIL edge_pwm k=%0d got %b exp %b", k, pwm_o, exp_pwm);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_center();
    logic [3:0] exp_pwm;
    load_and_start(10'd4, 1'b1, 10'd0, 10'd2);
    for (int k = 0; k < 24; k++) begin
      exp_pwm = 4'b0000;
      if (k > 0 && pwm_tab_c[k % 8] == 1) exp_pwm[1] = 1'b1;
      n_checks++;
      if (cnt_o !== 10'(cnt_tab_c[k % 8])) begin
        n_errors++; $display("FAIL center_cnt k=%0d got %0d exp %0d", k, cnt_o, cnt_tab_c[k % 8]);
      end
      n_checks++;
      if (pwm_o !== exp_pwm) begin
        n_errors++; $display("FAIL center_pwm k=%0d got %b exp %b", k, pwm_o, exp_pwm);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_update();
    int   done_cnt;
    int   duty;
    logic exp_b;
    done_cnt = 0;
    load_and_start(10'd9, 1'b0, 10'd3, 10'd0);
    for (int k = 0; k <= 20; k++) begin
      duty  = (k <= 10) ? 3 : 7;
      exp_b = (k > 0) && (((k - 1) % 10) < duty);
      n_checks++;
      if (cnt_o !== 10'(k % 10)) begin
        n_errors++; $display("FAIL upd_cnt k=%0d got %0d exp %0d", k, cnt_o, k % 10);
      end
      n_checks++;
      if (pwm_o[0] !== exp_b) begin
        n_errors++; $display("FAIL upd_pwm k=%0d got %b exp %b", k, pwm_o[0], exp_b);
      end
      if (k == 6) begin
        n_checks++;
        if (upd_pending !== 1'b1) begin n_errors++; $display("FAIL upd_pending_set got %b exp 1", upd_pending); end
      end
      if (k == 10) begin
        n_checks++;
        if (upd_done !== 1'b1) begin n_errors++; $display("FAIL upd_done_pulse got %b exp 1", upd_done); end
        n_checks++;
        if (upd_pending !== 1'b0) begin n_errors++; $display("FAIL upd_pending_clr got %b exp 0", upd_pending); end
      end
      if (upd_done === 1'b1) done_cnt++;
      if (k == 5) begin wr_en = 1'b1; wr_ch = 2'd0; wr_duty = 10'd7; end
      if (k == 6) wr_en = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (done_cnt != 1) begin n_errors++; $display("FAIL upd_done_count got %0d exp 1", done_cnt); end
  endtask

  task automatic test_boundary();
    logic [3:0] exp_pwm;
    // duty0=0 -> always inactive, duty1=10 > P=9 -> always active
    load_and_start(10'd9, 1'b0, 10'd0, 10'd10);
    for (int k = 0; k < 25; k++) begin
      exp_pwm = (k == 0) ? 4'b0000 : 4'b0010;
      n_checks++;
      if (pwm_o !== exp_pwm) begin
        n_errors++; $display("FAIL bnd_duty k=%0d got %b exp %b", k, pwm_o, exp_pwm);
      end
      @(negedge clk);
    end
    // P=0 -> count held at 0
    load_and_start(10'd0, 1'b0, 10'd0, 10'd10);
    for (int k = 0; k < 10; k++) begin
      exp_pwm = (k == 0) ? 4'b0000 : 4'b0010;
      n_checks++;
      if (cnt_o !== 10'd0) begin n_errors++; $display("FAIL bnd_p0_cnt k=%0d got %0d exp 0", k, cnt_o); end
      n_checks++;
      if (pwm_o !== exp_pwm) begin
        n_errors++; $display("FAIL bnd_p0_pwm k=%0d got %b exp %b", k, pwm_o, exp_pwm);
      end
      @(negedge clk);
    end
    // out-of-range channel writes on the 5-channel instance are ignored
    en5 = 1'b0; wr_en5 = 1'b1; wr_ch5 = 3'd5; wr_duty5 = 4'd3;
    @(negedge clk);
    n_checks++;
    if (upd_pending5 !== 1'b0) begin n_errors++; $display("FAIL bnd_ch5_ignored got %b exp 0", upd_pending5); end
    wr_ch5 = 3'd7;
    @(negedge clk);
    n_checks++;
    if (upd_pending5 !== 1'b0) begin n_errors++; $display("FAIL bnd_ch7_ignored got %b exp 0", upd_pending5); end
    wr_ch5 = 3'd4;
    @(negedge clk);
    n_checks++;
    if (upd_pending5 !== 1'b1) begin n_errors++; $display("FAIL bnd_ch4_pending got %b exp 1", upd_pending5); end
    wr_en5 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (upd_done5 !== 1'b1) begin n_errors++; $display("FAIL bnd_ch4_done got %b exp 1", upd_done5); end
    n_checks++;
    if (pwm5 !== 5'b10010) begin n_errors++; $display("FAIL bnd_inv_idle got %b exp %b", pwm5, 5'b10010); end
    en5 = 1'b1;
    @(negedge clk);
    n_checks++;
    if (pwm5 !== 5'b00010) begin n_errors++; $display("FAIL bnd_inv_run got %b exp %b", pwm5, 5'b00010); end
    n_checks++;
    if (cnt5 !== 4'd1) begin n_errors++; $display("FAIL bnd_cnt5 got %0d exp 1", cnt5); end
    en5 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (pwm5 !== 5'b10010) begin n_errors++; $display("FAIL bnd_inv_stop got %b exp %b", pwm5, 5'b10010); end
    n_checks++;
    if (cnt5 !== 4'd0) begin n_errors++; $display("FAIL bnd_cnt5_stop got %0d exp 0", cnt5); end
  endtask

  task automatic test_eop_write_and_reset();
    int   duty;
    logic exp_b;
    load_and_start(10'd9, 1'b0, 10'd3, 10'd0);
    for (int k = 0; k <= 26; k++) begin
      duty  = (k <= 10) ? 3 : ((k <= 20) ? 5 : 8);
      exp_b = (k > 0) && (((k - 1) % 10) < duty);
      n_checks++;
      if (cnt_o !== 10'(k % 10)) begin
        n_errors++; $display("FAIL eopw_cnt k=%0d got %0d exp %0d", k, cnt_o, k % 10);
      end
      n_checks++;
      if (pwm_o[0] !== exp_b) begin
        n_errors++; $display("FAIL eopw_pwm k=%0d got %b exp %b", k, pwm_o[0], exp_b);
      end
      if (k == 10) begin
        n_checks++;
        if (upd_done !== 1'b1) begin n_errors++; $display("FAIL eopw_done1 got %b exp 1", upd_done); end
        n_checks++;
        if (upd_pending !== 1'b1) begin n_errors++; $display("FAIL eopw_pending_kept got %b exp 1", upd_pending); end
      end
      if (k == 20) begin
        n_checks++;
        if (upd_done !== 1'b1) begin n_errors++; $display("FAIL eopw_done2 got %b exp 1", upd_done); end
        n_checks++;
        if (upd_pending !== 1'b0) begin n_errors++; $display("FAIL eopw_pending_clr got %b exp 0", upd_pending); end
      end
      if (k == 25) begin
        n_checks++;
        if (upd_pending !== 1'b1) begin n_errors++; $display("FAIL eopw_pending_pre_rst got %b exp 1", upd_pending); end
      end
      if (k == 5)  begin wr_en = 1'b1; wr_ch = 2'd0; wr_duty = 10'd5; end
      if (k == 6)  wr_en = 1'b0;
      if (k == 9)  begin wr_en = 1'b1; wr_ch = 2'd0; wr_duty = 10'd8; end
      if (k == 10) wr_en = 1'b0;
      if (k == 24) begin wr_en = 1'b1; wr_ch = 2'd1; wr_duty = 10'd4; end
      if (k == 25) wr_en = 1'b0;
      if (k == 26) arst = 1'b0;
      @(negedge clk);
    end
    // one cycle after reset asserted mid-period
    n_checks++;
    if (cnt_o !== 10'd0) begin n_errors++; $display("FAIL mid_rst_cnt got %0d exp 0", cnt_o); end
    n_checks++;
    if (pwm_o !== 4'b0000) begin n_errors++; $display("FAIL mid_rst_pwm got %b exp 0000", pwm_o); end
    n_checks++;
    if (upd_pending !== 1'b0) begin n_errors++; $display("FAIL mid_rst_pending got %b exp 0", upd_pending); end
    n_checks++;
    if (upd_done !== 1'b0) begin n_errors++; $display("FAIL mid_rst_done got %b exp 0", upd_done); end
    n_checks++;
    if (pwm5 !== 5'b10010) begin n_errors++; $display("FAIL mid_rst_pwm5 got %b exp %b", pwm5, 5'b10010); end
    arst = 1'b1;
    // default period (1023) is back: count runs past the old P=9
    for (int k = 0; k <= 12; k++) begin
      n_checks++;
      if (cnt_o !== 10'(k)) begin n_errors++; $display("FAIL post_rst_cnt k=%0d got %0d exp %0d", k, cnt_o, k); end
      n_checks++;
      if (pwm_o !== 4'b0000) begin n_errors++; $display("FAIL post_rst_pwm k=%0d got %b exp 0000", k, pwm_o); end
      n_checks++;
      if (upd_pending !== 1'b0) begin n_errors++; $display("FAIL post_rst_pending k=%0d got %b exp 0", k, upd_pending); end
      @(negedge clk);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_edge();
    test_center();
    test_update();
    test_boundary();
    test_eop_write_and_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #1000000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
